// File: rtl/note_lane_renderer_pkg.sv
// Shared colour types, palette and helpers for the note lane renderer.
// Pixel format is RRGGBB, two bits per channel.
package note_pkg;

  typedef logic [5:0] rgb6_t;

  localparam rgb6_t BLACK   = 6'b00_00_00;
  localparam rgb6_t RED     = 6'b11_00_00;
  localparam rgb6_t GREEN   = 6'b00_11_00;
  localparam rgb6_t BLUE    = 6'b00_00_11;
  localparam rgb6_t YELLOW  = 6'b11_11_00;
  localparam rgb6_t ORANGE  = 6'b11_10_00;
  localparam rgb6_t WHITE   = 6'b11_11_11;
  localparam rgb6_t MAGENTA = 6'b11_00_11;
  localparam rgb6_t CYAN    = 6'b00_11_11;

  localparam rgb6_t LANE_COLOURS [8] = '{
    GREEN, YELLOW, BLUE, ORANGE,
    RED, WHITE, MAGENTA, CYAN
  };

  // Halve each 2-bit channel: shift right, keep one bit per field.
  function automatic rgb6_t dim(input rgb6_t c);
    return (c >> 1) & 6'b01_01_01;
  endfunction

endpackage

// File: rtl/note_lane_renderer_if.sv
// Pixel/game bus between the timing + game side and the lane renderer.
// master drives coordinates and notes, slave returns pixels and exits.
interface note_lane_renderer_if
  import note_pkg::*;
#(
  parameter int NUM_LANES = 4
);

  logic [9:0]           col;
  logic [9:0]           row;
  logic                 valid;
  logic                 frame_start;
  logic                 pause;
  logic [NUM_LANES-1:0] note_in;
  rgb6_t                rgb;
  logic [NUM_LANES-1:0] note_out;

  modport master (
    output col, row, valid,
    output frame_start, pause, note_in,
    input  rgb, note_out
  );

  modport slave (
    input  col, row, valid,
    input  frame_start, pause, note_in,
    output rgb, note_out
  );

endinterface

// File: rtl/note_lane_renderer_store.sv
// Per-lane note shift registers and the shared scroll offset.
// A slot shift happens when the offset wraps past SLOT_H.
module note_lane_store
  import note_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int NUM_SLOTS   = 15,
  parameter int SLOT_H      = 32,
  parameter int SCROLL_STEP = 2,
  localparam int OW = $clog2(SLOT_H)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_frame_start,
  input  logic                                 i_pause,
  input  logic [NUM_LANES-1:0]                 i_note_in,
  output logic [OW-1:0]                        o_offset,
  output logic [NUM_LANES-1:0][NUM_SLOTS-1:0]  o_slots,
  output logic [NUM_LANES-1:0]                 o_note_out
);

  localparam logic [OW:0] STEP_V = SCROLL_STEP[OW:0];

  logic [OW-1:0]                       r_offset;
  logic [NUM_LANES-1:0][NUM_SLOTS-1:0] r_slots;
  logic [NUM_LANES-1:0]                r_note_out;

  logic [OW:0] w_sum;
  logic        w_step;
  logic        w_wrap;

  assign w_step = i_frame_start & ~i_pause;
  assign w_sum  = {1'b0, r_offset} + STEP_V;
  // SLOT_H is a power of two, so the carry bit marks sum >= SLOT_H.
  assign w_wrap = w_sum[OW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_offset   <= '0;
      r_slots    <= '0;
      r_note_out <= '0;
    end else begin
      r_note_out <= '0;
      if (w_step) begin
        r_offset <= w_sum[OW-1:0];
        if (w_wrap) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            r_note_out[l] <= r_slots[l][NUM_SLOTS-1];
            r_slots[l]    <= (r_slots[l] << 1)
                           | NUM_SLOTS'(i_note_in[l]);
          end
        end
      end
    end
  end

  assign o_offset   = r_offset;
  assign o_slots    = r_slots;
  assign o_note_out = r_note_out;

endmodule

// File: rtl/note_lane_renderer.sv
// Lane/note/hit-bar renderer with a one-cycle registered RGB output.
// Optional score panel when SCORE_PANEL_EN is defined.
module note_lane_renderer
  import note_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int FIRST_X     = 220,
  parameter int LANE_W      = 35,
  parameter int LANE_GAP    = 20,
  parameter int SLOT_H      = 32,
  parameter int NUM_SLOTS   = 15,
  parameter int NOTE_H      = 16,
  parameter int SCROLL_STEP = 2,
  parameter int HIT_Y       = 440,
  parameter int HIT_H       = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  note_lane_renderer_if.slave  bus
);

  localparam int OW = $clog2(SLOT_H);
  localparam logic [9:0]    NS_V  = 10'(NUM_SLOTS);
  localparam logic [OW-1:0] NH_V  = NOTE_H[OW-1:0];
  localparam logic [9:0]    HB_LO = 10'(HIT_Y);
  localparam logic [9:0]    HB_HI = 10'(HIT_Y + HIT_H);

  logic [OW-1:0]                       w_offset;
  logic [NUM_LANES-1:0][NUM_SLOTS-1:0] w_slots;
  logic [NUM_LANES-1:0]                w_note_out;

  note_lane_store #(
    .NUM_LANES   (NUM_LANES),
    .NUM_SLOTS   (NUM_SLOTS),
    .SLOT_H      (SLOT_H),
    .SCROLL_STEP (SCROLL_STEP)
  ) u_store (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_start (bus.frame_start),
    .i_pause       (bus.pause),
    .i_note_in     (bus.note_in),
    .o_offset      (w_offset),
    .o_slots       (w_slots),
    .o_note_out    (w_note_out)
  );

  assign bus.note_out = w_note_out;

  logic [9:0]    w_off10;
  logic [9:0]    w_d;
  logic [9:0]    w_s;
  logic [OW-1:0] w_r;
  logic          w_note_row;

  assign w_off10    = {{(10-OW){1'b0}}, w_offset};
  assign w_d        = bus.row - w_off10;
  assign w_s        = w_d >> OW;
  assign w_r        = w_d[OW-1:0];
  assign w_note_row = (bus.row >= w_off10)
                    && (w_s < NS_V)
                    && (w_r < NH_V);

  logic [NUM_LANES-1:0] w_lane_hit;
  rgb6_t                w_lane_rgb [NUM_LANES];

  for (genvar L = 0; L < NUM_LANES; L++) begin : g_lane
    localparam int    X0  = FIRST_X + L * (LANE_W + LANE_GAP);
    localparam logic [9:0] LO = 10'(X0);
    localparam logic [9:0] HI = 10'(X0 + LANE_W);
    localparam rgb6_t CLR = LANE_COLOURS[L % 8];

    logic [NUM_SLOTS-1:0] w_sel;
    logic                 w_lit;

    assign w_sel  = w_slots[L] >> w_s;
    assign w_lit  = w_note_row & w_sel[0];
    assign w_lane_hit[L] = (bus.col >= LO) && (bus.col < HI);
    assign w_lane_rgb[L] = w_lit ? CLR : dim(CLR);
  end

  logic w_panel;
`ifdef SCORE_PANEL_EN
  logic w_cell_col;
  logic w_panel_col;

  assign w_panel_col = (bus.col > 10'd20) && (bus.col < 10'd150);
  assign w_cell_col  =
      ((bus.col >= 10'd47)  && (bus.col <= 10'd71))
   || ((bus.col >= 10'd73)  && (bus.col <= 10'd97))
   || ((bus.col >= 10'd99)  && (bus.col <= 10'd123))
   || ((bus.col >= 10'd125) && (bus.col <= 10'd149));
  assign w_panel = w_panel_col && (
      ((bus.row > 10'd20) && (bus.row < 10'd60))
   || ((bus.row > 10'd70) && (bus.row < 10'd110) && w_cell_col));
`else
  assign w_panel = 1'b0;
`endif

  logic  w_in_lane;
  logic  w_hit_row;
  rgb6_t w_lane_px;
  rgb6_t w_pix;

  assign w_in_lane = |w_lane_hit;
  assign w_hit_row = (bus.row >= HB_LO) && (bus.row < HB_HI);

  // Lanes never overlap, so at most one entry is selected.
  always_comb begin
    w_lane_px = BLACK;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (w_lane_hit[l]) w_lane_px = w_lane_rgb[l];
    end
  end

  always_comb begin
    w_pix = BLACK;
    if (!bus.valid)
      w_pix = BLACK;
    else if (bus.col == 10'd1 || bus.col == 10'd639)
      w_pix = WHITE;
    else if (w_panel)
      w_pix = WHITE;
    else if (w_hit_row && w_in_lane)
      w_pix = WHITE;
    else if (w_in_lane)
      w_pix = w_lane_px;
  end

  rgb6_t r_rgb;

  always_ff @(posedge clk) begin
    if (!rst_n) r_rgb <= BLACK;
    else        r_rgb <= w_pix;
  end

  assign bus.rgb = r_rgb;

endmodule

// File: tb/tb_note_lane_renderer.sv
// Directed bench for note_lane_renderer (default parameters).
// Panel expectations follow SCORE_PANEL_EN.
module tb_note_lane_renderer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  note_lane_renderer_if #(.NUM_LANES(4)) bus ();

  note_lane_renderer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [5:0] px;
  logic [3:0] no;

  task automatic pix(input logic [9:0] c, input logic [9:0] r,
                     output logic [5:0] v);
    bus.col   = c;
    bus.row   = r;
    bus.valid = 1'b1;
    @(posedge clk); #1;
    v = bus.rgb;
    bus.valid = 1'b0;
  endtask

  task automatic frame(output logic [3:0] n);
    bus.valid       = 1'b0;
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    n = bus.note_out;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.valid = 1'b1;
    bus.col = 10'd230;
    bus.row = 10'd100;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rgb !== 6'b000000) begin
      errors++;
      $display("FAIL reset_rgb: got %b want 000000", bus.rgb);
    end
    checks++;
    if (bus.note_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_note_out: got %b want 0000", bus.note_out);
    end
    rst_n = 1'b1;
    pix(10'd230, 10'd100, px);
    checks++;
    if (px !== 6'b000100) begin
      errors++;
      $display("FAIL reset_dim_green: got %b want 000100", px);
    end
    pix(10'd256, 10'd100, px);
    checks++;
    if (px !== 6'b000000) begin
      errors++;
      $display("FAIL reset_gap: got %b want 000000", px);
    end
  endtask

  task automatic test_insert;
    bus.note_in = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      frame(no);
      checks++;
      if (no !== 4'b0000) begin
        errors++;
        $display("FAIL insert_note_out f%0d: got %b want 0000", i, no);
      end
    end
    bus.note_in = 4'b0000;
    pix(10'd230, 10'd5, px);
    checks++;
    if (px !== 6'b001100) begin
      errors++;
      $display("FAIL insert_lit: got %b want 001100", px);
    end
    pix(10'd230, 10'd20, px);
    checks++;
    if (px !== 6'b000100) begin
      errors++;
      $display("FAIL insert_tail: got %b want 000100", px);
    end
    pix(10'd285, 10'd5, px);
    checks++;
    if (px !== 6'b010100) begin
      errors++;
      $display("FAIL insert_lane1: got %b want 010100", px);
    end
  endtask

  task automatic test_travel;
    for (int p = 1; p <= 240; p++) begin
      frame(no);
      checks++;
      if (p < 240 && no !== 4'b0000) begin
        errors++;
        $display("FAIL travel_early p%0d: got %b want 0000", p, no);
      end else if (p == 240 && no !== 4'b0001) begin
        errors++;
        $display("FAIL travel_exit: got %b want 0001", no);
      end
      if (p == 8) begin
        pix(10'd230, 10'd20, px);
        checks++;
        if (px !== 6'b001100) begin
          errors++;
          $display("FAIL travel_p8_lit: got %b want 001100", px);
        end
        pix(10'd230, 10'd10, px);
        checks++;
        if (px !== 6'b000100) begin
          errors++;
          $display("FAIL travel_p8_above: got %b want 000100", px);
        end
      end
      if (p == 220) begin
        pix(10'd230, 10'd450, px);
        checks++;
        if (px !== 6'b001100) begin
          errors++;
          $display("FAIL travel_near_bar: got %b want 001100", px);
        end
        pix(10'd230, 10'd444, px);
        checks++;
        if (px !== 6'b001100) begin
          errors++;
          $display("FAIL travel_below_bar: got %b want 001100", px);
        end
      end
      if (p % 16 == 4) begin
        pix(10'd230, 10'(440 + (p / 16) % 4), px);
        checks++;
        if (px !== 6'b111111) begin
          errors++;
          $display("FAIL travel_hitbar p%0d: got %b want 111111", p, px);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.note_out !== 4'b0000) begin
      errors++;
      $display("FAIL travel_pulse_width: got %b want 0000", bus.note_out);
    end
  endtask

  task automatic test_pause;
    bus.note_in = 4'b0010;
    repeat (16) frame(no);
    bus.note_in = 4'b0000;
    repeat (4) frame(no);
    pix(10'd285, 10'd10, px);
    checks++;
    if (px !== 6'b111100) begin
      errors++;
      $display("FAIL pause_pre: got %b want 111100", px);
    end
    bus.pause = 1'b1;
    bus.note_in = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      frame(no);
      checks++;
      if (no !== 4'b0000) begin
        errors++;
        $display("FAIL pause_note_out f%0d: got %b want 0000", i, no);
      end
    end
    pix(10'd285, 10'd8, px);
    checks++;
    if (px !== 6'b111100) begin
      errors++;
      $display("FAIL pause_top: got %b want 111100", px);
    end
    pix(10'd285, 10'd7, px);
    checks++;
    if (px !== 6'b010100) begin
      errors++;
      $display("FAIL pause_above: got %b want 010100", px);
    end
    pix(10'd230, 10'd10, px);
    checks++;
    if (px !== 6'b000100) begin
      errors++;
      $display("FAIL pause_no_insert: got %b want 000100", px);
    end
    bus.pause = 1'b0;
    bus.note_in = 4'b0000;
    frame(no);
    pix(10'd285, 10'd8, px);
    checks++;
    if (px !== 6'b010100) begin
      errors++;
      $display("FAIL unpause_moved: got %b want 010100", px);
    end
    pix(10'd285, 10'd10, px);
    checks++;
    if (px !== 6'b111100) begin
      errors++;
      $display("FAIL unpause_lit: got %b want 111100", px);
    end
  endtask

  task automatic test_priority;
    logic [9:0] cs [8];
    logic [9:0] rs [8];
    logic [5:0] ex [8];
    cs = '{10'd639, 10'd1, 10'd0, 10'd638,
           10'd254, 10'd255, 10'd219, 10'd220};
    rs = '{10'd100, 10'd100, 10'd100, 10'd100,
           10'd100, 10'd100, 10'd100, 10'd100};
    ex = '{6'b111111, 6'b111111, 6'b000000, 6'b000000,
           6'b000100, 6'b000000, 6'b000000, 6'b000100};
    for (int i = 0; i < 8; i++) begin
      pix(cs[i], rs[i], px);
      checks++;
      if (px !== ex[i]) begin
        errors++;
        $display("FAIL prio_col%0d: got %b want %b", cs[i], px, ex[i]);
      end
    end
    bus.valid = 1'b0;
    bus.col = 10'd639;
    bus.row = 10'd441;
    @(posedge clk); #1;
    checks++;
    if (bus.rgb !== 6'b000000) begin
      errors++;
      $display("FAIL prio_invalid: got %b want 000000", bus.rgb);
    end
    pix(10'd400, 10'd441, px);
    checks++;
    if (px !== 6'b111111) begin
      errors++;
      $display("FAIL prio_bar_lane3: got %b want 111111", px);
    end
    pix(10'd256, 10'd441, px);
    checks++;
    if (px !== 6'b000000) begin
      errors++;
      $display("FAIL prio_bar_gap: got %b want 000000", px);
    end
    pix(10'd230, 10'd439, px);
    checks++;
    if (px !== 6'b000100) begin
      errors++;
      $display("FAIL prio_above_bar: got %b want 000100", px);
    end
  endtask

  task automatic test_panel;
    logic [5:0] ex;
`ifdef SCORE_PANEL_EN
    ex = 6'b111111;
`else
    ex = 6'b000000;
`endif
    pix(10'd50, 10'd40, px);
    checks++;
    if (px !== ex) begin
      errors++;
      $display("FAIL panel_header: got %b want %b", px, ex);
    end
    pix(10'd60, 10'd90, px);
    checks++;
    if (px !== ex) begin
      errors++;
      $display("FAIL panel_cell: got %b want %b", px, ex);
    end
    pix(10'd72, 10'd90, px);
    checks++;
    if (px !== 6'b000000) begin
      errors++;
      $display("FAIL panel_cell_gap: got %b want 000000", px);
    end
  endtask

  task automatic test_reset_mid;
    pix(10'd285, 10'd12, px);
    checks++;
    if (px !== 6'b111100) begin
      errors++;
      $display("FAIL mid_pre: got %b want 111100", px);
    end
    bus.valid = 1'b1;
    bus.col = 10'd285;
    bus.row = 10'd12;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.rgb !== 6'b000000) begin
      errors++;
      $display("FAIL mid_black: got %b want 000000", bus.rgb);
    end
    rst_n = 1'b1;
    pix(10'd285, 10'd12, px);
    checks++;
    if (px !== 6'b010100) begin
      errors++;
      $display("FAIL mid_cleared: got %b want 010100", px);
    end
  endtask

  initial begin
    bus.col = '0;
    bus.row = '0;
    bus.valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.pause = 1'b0;
    bus.note_in = '0;
    test_reset;
    test_insert;
    test_travel;
    test_pause;
    test_priority;
    test_panel;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_lane_renderer.md
Name: note_lane_renderer

Overview:
- Parametrised successor to the static stripe generator: draws NUM_LANES coloured lanes with falling notes that scroll down once per frame, plus a white hit bar.
- Sits between the VGA timing block (col/row/valid/frame_start) and the 6-bit RGB output pins.
- Holds per-lane note shift registers fed by game logic. Registered pixel output.

Parameters:
- NUM_LANES, 4, lane count (1..8)
- FIRST_X, 220, left column of lane 0
- LANE_W, 35, lane width in pixels
- LANE_GAP, 20, gap between lanes in pixels
- SLOT_H, 32, rows per note slot (power of two)
- NUM_SLOTS, 15, slots per lane (NUM_SLOTS*SLOT_H <= 480)
- NOTE_H, 16, drawn note height in rows (< SLOT_H)
- SCROLL_STEP, 2, rows scrolled per frame (< SLOT_H)
- HIT_Y, 440, first row of hit bar
- HIT_H, 4, hit bar height

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- col  in  10  current pixel column
- row  in  10  current pixel row
- valid  in  1  active-video qualifier
- frame_start  in  1  one-cycle pulse, issued only during blanking
- pause  in  1  freezes scrolling while high
- note_in  in  NUM_LANES  notes to insert at the top on the next slot shift
- rgb  out  6  RRGGBB pixel, registered
- note_out  out  NUM_LANES  one-cycle pulse of bottom-slot notes leaving the screen

Behaviour:
- Reset is synchronous: rst_n low at a clk edge → offset=0, all note slots=0, rgb=0, note_out=0.
- Scroll state: offset register, width log2(SLOT_H). Updates only on a cycle where frame_start=1 and pause=0.
- Scroll update:
  - sum = offset + SCROLL_STEP.
  - sum < SLOT_H → offset=sum, no shift.
  - sum >= SLOT_H → offset = sum - SLOT_H, and shift every lane down by one slot in the same cycle:
    - slot[0] ← note_in[lane]
    - slot[k] ← slot[k-1]
    - note_out ← slot[NUM_SLOTS-1] for exactly one cycle
- note_out is 0 on every other cycle.
- pause=1 together with frame_start: no update (pause wins). note_in is ignored unless a shift occurs.
- Lane geometry:
  - lane L spans FIRST_X + L*(LANE_W+LANE_GAP) <= col < that + LANE_W.
  - Lane colour comes from the package table, index L mod 8.
- Note hit test, for pixel (col,row) inside lane L:
  - condition row >= offset; d = row - offset; s = d / SLOT_H (shift); r = d mod SLOT_H.
  - The note pixel is lit when s < NUM_SLOTS, slot[s]=1 and r < NOTE_H.
- Pixel priority (highest first):
  1. valid=0 → black
  2. col==1 or col==639 → white border
  3. HIT_Y <= row < HIT_Y+HIT_H and col inside any lane → white
  4. lit note pixel → lane colour
  5. inside lane, not lit → dim lane colour: each 2-bit field shifted right by 1
  6. everything else → black
- Latency: rgb reflects the col/row/valid sampled on the previous edge (exactly 1 cycle). The timing block delays syncs to match.
- Offset and notes change only during blanking, so a frame never tears.
- Reset mid-frame: rgb is black from the next cycle; rendering resumes on the following edge with an empty field.

Optional Feature:
- Macro: SCORE_PANEL_EN.
- Defined:
  - Draws the score panel for 20 < col < 150: white header for 20 < row < 60.
  - Four white digit cells for 70 < row < 110, at cols 47..71, 73..97, 99..123, 125..149.
  - The panel sits below the border in priority and above the lanes.
- Undefined: that region renders black; no extra logic.
- Lane parameters must keep lanes clear of col < 150 when the macro is enabled.

Decomposition:
- Package note_pkg holds:
  - rgb6_t typedef
  - colour constants RED, GREEN, BLUE, YELLOW, ORANGE, WHITE, BLACK
  - LANE_COLOURS[8] table: green, yellow, blue, orange, red, white, …
  - dim() function
- Sub-module note_lane_store:
  - Per-lane NUM_SLOTS shift register plus the offset counter.
  - Outputs the slot vector, offset and note_out.
  - The top level does geometry and the output register.

Test Plan:
- Reset behaviour: rst_n=0 for 3 cycles with valid=1 → rgb=0 and note_out=0. After release, pixel (230,100) = dim green 6'b000100, no notes visible.
- Insert and scroll: note_in=4'b0001, then 16 frame_start pulses (STEP=2, SLOT_H=32).
  - After pulse 16: offset=0, slot[0] of lane 0 set.
  - Pixel (230,5) = GREEN, pixel (230,20) = dim green.
- Note travel: keep scrolling with note_in=0.
  - note_out=4'b0001 pulses one cycle exactly NUM_SLOTS*16 = 240 frames after insertion.
  - The note passes the hit bar, and rows 440..443 stay white throughout.
- Pause: pause=1 across 5 frame_start pulses → offset and slots unchanged, rgb stream identical frame to frame.
- Priority and latency: col=639 with valid=1 → rgb=WHITE one cycle later. valid=0 at any col → black. Pixel in a lane gap (col 256) → black.
- SCORE_PANEL_EN on/off: pixel (50,40) is WHITE with the macro defined and BLACK without it. Pixel (60,90) is WHITE with the macro defined.
